// File: rtl/uart_tx_queue_if.sv
// Handshake bundle between a byte producer, uart_tx_queue and uart_tx.
// The slave modport is the queue. The master modport is everything around it:
// the host write port plus the tx_done return from uart_tx.
interface uart_tx_queue_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          overflow;
    logic          tx_en;
    logic [7:0]    tx_data;
    logic          tx_done;
    logic          busy;
    logic          tx_timeout;

    modport master (
        output wr_en, wr_data, tx_done,
        input  full, empty, level, overflow, tx_en, tx_data, busy, tx_timeout
    );

    modport slave (
        input  wr_en, wr_data, tx_done,
        output full, empty, level, overflow, tx_en, tx_data, busy, tx_timeout
    );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO and frame sequencer in front of uart_tx. Producers may write
// back-to-back; bytes are issued one frame at a time, and the next tx_en is
// only raised after the previous frame reports tx_done.
//
// Optional feature: define UART_TXQ_TIMEOUT_EN to add a WAIT watchdog. When
// the watchdog expires it pulses tx_timeout, drops the byte and re-enters
// HOLDOFF. TIMEOUT_CYCLES must be at least 2.
//
// state   | meaning
// HOLDOFF | uart_tx may still be in flight after our reset; wait 15 bit times
// IDLE    | sequencer free; start a frame when the FIFO is not empty
// LOAD    | pop the head byte into tx_data
// FIRE    | one-cycle tx_en pulse toward uart_tx
// WAIT    | frame in flight; wait for tx_done (optionally with a watchdog)
// GAP     | optional idle spacing between frames
module uart_tx_queue #(
    parameter int DEPTH          = 16,
    parameter int CYCLES_PER_BIT = 434,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic           clk_50M,
    input  logic           rst,
    uart_tx_queue_if.slave bus
);
    localparam int AW             = $clog2(DEPTH);
    localparam int HOLDOFF_CYCLES = 15 * (CYCLES_PER_BIT + 1);
    localparam int CNT_MAX        = (HOLDOFF_CYCLES > GAP_CYCLES) ? HOLDOFF_CYCLES : GAP_CYCLES;
    localparam int CW             = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HOLDOFF_LOAD = CW'(HOLDOFF_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD     = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [AW:0]   DEPTH_LVL    = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_HOLDOFF,
        S_IDLE,
        S_LOAD,
        S_FIRE,
        S_WAIT,
        S_GAP
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          overflow_q;
    logic          full_w;
    logic          empty_w;
    logic          pop;
    logic          push;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          tx_en_q;
    logic [7:0]    tx_data_q;
    logic          busy_q;

`ifdef UART_TXQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wdog;
    logic          tx_timeout_q;
`endif

    assign full_w  = (count == DEPTH_LVL);
    assign empty_w = (count == '0);
    // LOAD is only entered from IDLE with a non-empty FIFO, so it always pops.
    assign pop     = (state == S_LOAD);
    // A pop in the same cycle frees the slot a write to a full FIFO needs.
    assign push    = bus.wr_en && (!full_w || pop);

    // Storage array; left unreset because the pointers define what is valid.
    always_ff @(posedge clk_50M) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end

    // FIFO pointers, occupancy and the sticky dropped-write flag.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (bus.wr_en && !push) overflow_q <= 1'b1;
        end
    end

    // Frame sequencer; every output it drives is registered.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state     <= S_HOLDOFF;
            cnt       <= HOLDOFF_LOAD;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
            busy_q    <= 1'b1;
`ifdef UART_TXQ_TIMEOUT_EN
            wdog         <= '0;
            tx_timeout_q <= 1'b0;
`endif
        end else begin
            tx_en_q <= 1'b0;
`ifdef UART_TXQ_TIMEOUT_EN
            tx_timeout_q <= 1'b0;
`endif
            unique case (state)
                S_HOLDOFF: begin
                    if (cnt == '0) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_IDLE: begin
                    if (!empty_w) begin
                        state  <= S_LOAD;
                        busy_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    tx_data_q <= mem[rd_ptr];
                    tx_en_q   <= 1'b1;
                    state     <= S_FIRE;
                end
                S_FIRE: begin
                    state <= S_WAIT;
`ifdef UART_TXQ_TIMEOUT_EN
                    wdog  <= TW'(TIMEOUT_CYCLES - 1);
`endif
                end
                S_WAIT: begin
                    if (bus.tx_done) begin
                        if (GAP_CYCLES > 0) begin
                            state <= S_GAP;
                            cnt   <= GAP_LOAD;
                        end else begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end
                    end
`ifdef UART_TXQ_TIMEOUT_EN
                    else if (wdog == TW'(1)) begin
                        tx_timeout_q <= 1'b1;
                        state        <= S_HOLDOFF;
                        cnt          <= HOLDOFF_LOAD;
                    end else begin
                        wdog <= wdog - 1'b1;
                    end
`endif
                end
                S_GAP: begin
                    if (cnt == '0) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= S_HOLDOFF;
                    cnt    <= HOLDOFF_LOAD;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.full     = full_w;
    assign bus.empty    = empty_w;
    assign bus.level    = count;
    assign bus.overflow = overflow_q;
    assign bus.tx_en    = tx_en_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = busy_q;
`ifdef UART_TXQ_TIMEOUT_EN
    assign bus.tx_timeout = tx_timeout_q;
`else
    assign bus.tx_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue. A timestamp-based reference model (byte queue plus
// "idle from cycle" / "fires in cycle" bookkeeping) predicts every output on
// every cycle; a small uart_tx stand-in returns tx_done after a chosen or
// random frame time and can inject stray tx_done pulses.
module tb_uart_tx_queue;
    localparam int DEPTH = 16;
    localparam int CPB   = 434;
    localparam int GAP   = 0;
    localparam int TMO   = 100;
    localparam int H     = 15 * (CPB + 1);

    logic clk_50M = 1'b0;
    logic rst     = 1'b1;
    always #10 clk_50M = ~clk_50M;

    uart_tx_queue_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_queue #(
        .DEPTH         (DEPTH),
        .CYCLES_PER_BIT(CPB),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_50M(clk_50M),
        .rst    (rst),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle-time %0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         cyc       = 0;
    bit         m_valid   = 0;
    logic [7:0] mq[$];
    bit         m_ovf     = 0;
    logic [7:0] m_data    = 8'h00;
    bit         m_tmo     = 0;
    int         idle_from = -1;  // first cycle the sequencer is free
    int         load_cyc  = -1;  // cycle in which the head byte is taken
    int         fire_cyc  = -1;  // cycle of tx_en for the frame in flight

    always @(posedge clk_50M) begin : model
        bit had;
        cyc++;
        m_tmo = 0;
        if (rst) begin
            mq.delete();
            m_ovf     = 0;
            m_data    = 8'h00;
            idle_from = cyc + H;
            load_cyc  = -1;
            fire_cyc  = -1;
            m_valid   = 1;
        end else if (m_valid) begin
            had = (mq.size() > 0);
            if (load_cyc == cyc - 1) begin
                m_data   = mq.pop_front();
                fire_cyc = cyc;
                load_cyc = -1;
            end
            if (bus.wr_en) begin
                if (mq.size() < DEPTH) mq.push_back(bus.wr_data);
                else m_ovf = 1;
            end
            if (idle_from >= 0 && cyc - 1 >= idle_from && had) begin
                load_cyc  = cyc;
                idle_from = -1;
            end
            if (fire_cyc >= 0 && cyc - 1 > fire_cyc) begin
                if (bus.tx_done) begin
                    idle_from = cyc + GAP;
                    fire_cyc  = -1;
                end
`ifdef UART_TXQ_TIMEOUT_EN
                else if (cyc - fire_cyc == TMO) begin
                    m_tmo     = 1;
                    fire_cyc  = -1;
                    idle_from = cyc + H;
                end
`endif
            end
        end
    end

    // ---------------- per-cycle compare + capture of issued bytes ----------------
    logic [7:0] sent[$];

    always @(negedge clk_50M) begin : compare
        if (m_valid) begin
            check("tx_en",      32'(bus.tx_en),      32'(fire_cyc == cyc));
            check("busy",       32'(bus.busy),       32'(!(idle_from >= 0 && cyc >= idle_from)));
            check("level",      32'(bus.level),      32'(mq.size()));
            check("full",       32'(bus.full),       32'(mq.size() == DEPTH));
            check("empty",      32'(bus.empty),      32'(mq.size() == 0));
            check("overflow",   32'(bus.overflow),   32'(m_ovf));
            check("tx_data",    32'(bus.tx_data),    32'(m_data));
            check("tx_timeout", 32'(bus.tx_timeout), 32'(m_tmo));
            if (bus.tx_en) sent.push_back(bus.tx_data);
        end
    end

    // ---------------- uart_tx stand-in ----------------
    int stub_mode      = 0;   // 0 silent, 1 fixed frame time, 2 random + stray pulses
    int done_dly       = 10;
    int stub_cnt       = 0;
    bit stub_pend      = 0;
    int last_done_edge = -1;

    always @(negedge clk_50M) begin : stub
        logic d;
        d = 1'b0;
        if (stub_pend) begin
            if (stub_cnt == 0) begin
                d              = 1'b1;
                stub_pend      = 0;
                last_done_edge = cyc + 1;
            end else begin
                stub_cnt--;
            end
        end else if (stub_mode == 2 && $urandom_range(0, 63) == 0) begin
            d = 1'b1;
        end
        if (bus.tx_en && stub_mode != 0) begin
            stub_pend = 1;
            stub_cnt  = (stub_mode == 1) ? done_dly : int'($urandom_range(0, 40));
        end
        bus.tx_done = d;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk_50M);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int lim, output int n, output int ens);
        n = 0;
        ens = 0;
        while (bus.busy && n < lim) begin
            if (bus.tx_en) ens++;
            n++;
            tick();
        end
        check("idle_reached", 32'(n < lim), 1);
    endtask

    task automatic wait_en(input int lim, output int n);
        n = 0;
        while (!bus.tx_en && n < lim) begin
            tick();
            n++;
        end
        check("tx_en_seen", 32'(bus.tx_en), 1);
    endtask

    task automatic wait_drain(input int lim);
        int n;
        n = 0;
        while (!(bus.empty && !bus.busy) && n < lim) begin
            tick();
            n++;
        end
        check("drained", 32'(n < lim), 1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin : main
        int n;
        int ens;
        int wcyc;
        int rcyc;
        int p;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;

        // Reset values and HOLDOFF length
        tick();
        check("rst_level",    32'(bus.level),    0);
        check("rst_empty",    32'(bus.empty),    1);
        check("rst_full",     32'(bus.full),     0);
        check("rst_busy",     32'(bus.busy),     1);
        check("rst_tx_data",  32'(bus.tx_data),  0);
        check("rst_overflow", 32'(bus.overflow), 0);
        rst = 1'b0;
        wait_idle(H + 100, n, ens);
        check("holdoff_len", 32'(n), 32'(6525));

        // Single byte: tx_en on the third clock after the write edge
        stub_mode = 1;
        done_dly  = 30;
        wr(8'hA5);
        wcyc = cyc;
        wait_en(50, n);
        check("wr_latency", 32'(cyc - wcyc + 1), 3);
        check("first_data", 32'(bus.tx_data), 32'h0A5);

        // Burst while the A5 frame is in flight
        tick();
        for (int i = 1; i <= 4; i++) wr(8'(i));
        check("burst_level", 32'(bus.level), 4);
        for (int k = 1; k <= 4; k++) begin
            tick();
            wait_en(200, n);
            check("done_to_en", 32'(cyc - last_done_edge + 1), 3);
            check("burst_data", 32'(bus.tx_data), 32'(k));
            check("burst_lvl",  32'(bus.level), 32'(4 - k));
        end
        wait_drain(500);

        // 17 writes during HOLDOFF: one dropped, never sent
        done_dly = 2;
        do_reset();
        sent.delete();
        for (int i = 0; i < 17; i++) wr(8'(8'h10 + i));
        check("ovf_full",  32'(bus.full),     1);
        check("ovf_flag",  32'(bus.overflow), 1);
        check("ovf_level", 32'(bus.level),    16);
        wait_drain(H + 2000);
        check("ovf_sent_n",    32'(sent.size()), 16);
        check("ovf_sent_last", 32'(sent[15]),    32'h1F);

        // Full queue, write lands in the LOAD cycle
        do_reset();
        sent.delete();
        for (int i = 0; i < 16; i++) wr(8'(8'h30 + i));
        check("fill_level", 32'(bus.level), 16);
        wait_idle(H + 100, n, ens);
        tick();
        wr(8'h5A);
        check("ld_wr_ovf",   32'(bus.overflow), 0);
        check("ld_wr_level", 32'(bus.level),    16);
        check("ld_wr_fire",  32'(bus.tx_data),  32'h30);
        wait_drain(2000);
        check("ld_sent_n",    32'(sent.size()), 17);
        check("ld_sent_last", 32'(sent[16]),    32'h5A);

        // Reset in mid-frame; orphaned tx_done arrives during HOLDOFF
        done_dly = 3000;
        wr(8'h77);
        wait_en(50, n);
        repeat (500) tick();
        do_reset();
        rcyc = cyc;
        done_dly = 5;
        wr(8'h99);
        wait_idle(H + 100, n, ens);
        check("holdoff_silent", 32'(ens), 0);
        check("stray_in_holdoff", 32'(last_done_edge > rcyc && last_done_edge < rcyc + H), 1);
        wait_en(10, n);
        check("post_rst_data", 32'(bus.tx_data), 32'h99);
        check("post_rst_time", 32'(cyc - rcyc), 32'(H + 2));
        wait_drain(200);

        // Watchdog (or its absence)
        stub_mode = 0;
        wr(8'hC3);
        wait_en(50, n);
`ifdef UART_TXQ_TIMEOUT_EN
        n = 0;
        while (!bus.tx_timeout && n < TMO + 50) begin
            tick();
            n++;
        end
        check("tmo_delay", 32'(n), 32'(TMO));
        check("tmo_busy",  32'(bus.busy), 1);
        wait_idle(H + 100, n, ens);
        check("tmo_holdoff", 32'(n), 32'(H));
`else
        repeat (TMO + 200) tick();
        check("no_tmo_busy",  32'(bus.busy), 1);
        check("no_tmo_level", 32'(bus.level), 0);
`endif

        // Randomized traffic against the model
        do_reset();
        stub_mode = 2;
        repeat (300) begin
            bus.wr_en   = ($urandom_range(0, 99) < 50);
            bus.wr_data = 8'($urandom);
            tick();
        end
        bus.wr_en = 1'b0;
        wait_idle(H + 100, n, ens);
        for (int w = 0; w < 8; w++) begin
            p = (w % 2 == 1) ? 70 : 6;
            repeat (600) begin
                bus.wr_en   = ($urandom_range(0, 99) < p);
                bus.wr_data = 8'($urandom);
                tick();
            end
        end
        bus.wr_en = 1'b0;
        stub_mode = 1;
        done_dly  = 3;
        wait_drain(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : guard
        #(20 * 150000);
        n_fail++;
        $display("FAIL global_timeout: simulation did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
